// File: rtl/split_compensate_scan_ctrl.sv
// Frame-scan controller: walks x/y across a frame, handshakes each pixel with the
// split-compensate address generator and presents a valid/ready read to the line buffer.
module split_compensate_scan_ctrl #(
  parameter int unsigned C_WIDTH        = 640,
  parameter int unsigned C_HEIGHT       = 480,
  parameter int unsigned C_DONE_TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [31:0] i_x_off,
  input  logic [31:0] i_dir,
  input  logic        i_x_done,
  input  logic [9:0]  i_new_addr,
  input  logic        i_rd_ready,
  output logic        o_x_enable,
  output logic [31:0] o_x_off,
  output logic [31:0] o_dir,
  output logic [9:0]  o_x_cnt,
  output logic [10:0] o_y_cnt,
  output logic        o_rd_valid,
  output logic [9:0]  o_rd_addr,
  output logic        o_rd_blank,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_err
);

  localparam int unsigned CntW = (C_DONE_TIMEOUT < 2) ? 1 : $clog2(C_DONE_TIMEOUT);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(C_DONE_TIMEOUT - 1);
  localparam logic [9:0]      XLast       = 10'(C_WIDTH - 1);
  localparam logic [10:0]     YLast       = 11'(C_HEIGHT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitDone,
    StPresent,
    StAdvance,
    StFin
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] tcnt_q;
  logic            x_enable_q;
  logic [31:0]     x_off_q;
  logic [31:0]     dir_q;
  logic [9:0]      x_cnt_q;
  logic [10:0]     y_cnt_q;
  logic            rd_valid_q;
  logic [9:0]      rd_addr_q;
  logic            rd_blank_q;
  logic            busy_q;
  logic            frame_done_q;
  logic            err_q;

  // Out-of-line test done at full width so huge offsets never wrap into range.
  logic [32:0] right_sum;
  logic        blank_left;
  logic        blank_right;
  logic        pix_blank;

  always_comb begin
    right_sum   = {1'b0, x_off_q} + {23'd0, x_cnt_q};
    blank_left  = x_off_q > {22'd0, x_cnt_q};
    blank_right = right_sum >= 33'(C_WIDTH);
    pix_blank   = (dir_q == '0) ? blank_left : blank_right;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      tcnt_q       <= '0;
      x_enable_q   <= 1'b0;
      x_off_q      <= '0;
      dir_q        <= '0;
      x_cnt_q      <= '0;
      y_cnt_q      <= '0;
      rd_valid_q   <= 1'b0;
      rd_addr_q    <= '0;
      rd_blank_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            x_off_q    <= i_x_off;
            dir_q      <= i_dir;
            x_cnt_q    <= '0;
            y_cnt_q    <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b1;
            x_enable_q <= 1'b1;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          x_enable_q <= 1'b0;
          tcnt_q     <= '0;
          state_q    <= StWaitDone;
        end
        StWaitDone: begin
          tcnt_q <= tcnt_q + CntW'(1);
          // A done on the final waiting cycle still wins over the timeout.
          if (i_x_done) begin
            rd_addr_q  <= i_new_addr;
            rd_blank_q <= pix_blank;
            rd_valid_q <= 1'b1;
            state_q    <= StPresent;
          end else if (tcnt_q == TimeoutLast) begin
            err_q      <= 1'b1;
            rd_addr_q  <= '0;
            rd_blank_q <= 1'b1;
            rd_valid_q <= 1'b1;
            state_q    <= StPresent;
          end
        end
        StPresent: begin
          if (i_rd_ready) begin
            rd_valid_q <= 1'b0;
            state_q    <= StAdvance;
          end
        end
        StAdvance: begin
          if (x_cnt_q == XLast) begin
            x_cnt_q <= '0;
            if (y_cnt_q == YLast) begin
              busy_q       <= 1'b0;
              frame_done_q <= 1'b1;
              state_q      <= StFin;
            end else begin
              y_cnt_q    <= y_cnt_q + 11'd1;
              x_enable_q <= 1'b1;
              state_q    <= StIssue;
            end
          end else begin
            x_cnt_q    <= x_cnt_q + 10'd1;
            x_enable_q <= 1'b1;
            state_q    <= StIssue;
          end
        end
        StFin: begin
          frame_done_q <= 1'b0;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_x_enable   = x_enable_q;
  assign o_x_off      = x_off_q;
  assign o_dir        = dir_q;
  assign o_x_cnt      = x_cnt_q;
  assign o_y_cnt      = y_cnt_q;
  assign o_rd_valid   = rd_valid_q;
  assign o_rd_addr    = rd_addr_q;
  assign o_rd_blank   = rd_blank_q;
  assign o_busy       = busy_q;
  assign o_frame_done = frame_done_q;
  assign o_err        = err_q;

  // Enable is a one-cycle strobe and never coincides with a pending read.
  assert property (@(posedge i_clk) disable iff (!i_rst_n) o_x_enable |=> !o_x_enable);
  assert property (@(posedge i_clk) disable iff (!i_rst_n) !(o_x_enable && o_rd_valid));

endmodule

// File: doc/split_compensate_scan_ctrl.md
Name: split_compensate_scan_ctrl

Overview:
- Frame-scan controller for the split-compensate horizontal address generator.
- Steps x/y counters across a frame and latches offset/direction once per frame.
- Per pixel, enables the address generator, waits for its done pulse and captures the generated address.
- Emits a read request to the line buffer via valid/ready, flagging pixels whose shifted source lies outside the line as blank.

Parameters:
- C_WIDTH, 640, active pixels per line (1..1023).
- C_HEIGHT, 480, lines per frame (1..2047).
- C_DONE_TIMEOUT, 15, max cycles to wait for address-gen done before error.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset: one clock; reset is synchronous and active-low.
- i_start  in  1  frame start pulse; ignored unless IDLE.
- i_x_off  in  32  horizontal offset magnitude, sampled on accepted i_start.
- i_dir  in  32  shift direction (0 = left, nonzero = right), sampled with i_x_off.
- i_x_done  in  1  done from address generator.
- i_new_addr  in  10  generated address from address generator.
- i_rd_ready  in  1  line-buffer consumer ready.
- o_x_enable  out  1  enable to address generator.
- o_x_off  out  32  latched offset to address generator.
- o_dir  out  32  latched direction to address generator.
- o_x_cnt  out  10  current pixel column.
- o_y_cnt  out  11  current line.
- o_rd_valid  out  1  read request valid.
- o_rd_addr  out  10  read address (captured i_new_addr).
- o_rd_blank  out  1  source out of line; consumer outputs black.
- o_busy  out  1  frame in progress.
- o_frame_done  out  1  one-cycle pulse after last pixel accepted.
- o_err  out  1  sticky done-timeout flag; cleared on accepted i_start.

Behaviour:
- Reset (i_rst_n = 0 at clock edge): state IDLE; all outputs 0, counters 0, timeout counter 0. Reset mid-frame aborts immediately; no o_frame_done.
- States: IDLE, ISSUE, WAIT_DONE, PRESENT, ADVANCE, FIN.
- IDLE:
  - On i_start: latch offset/direction into o_x_off/o_dir, clear x/y and o_err, set o_busy, go to ISSUE.
- ISSUE:
  - Assert o_x_enable for exactly 1 cycle, clear timeout counter, go to WAIT_DONE.
- WAIT_DONE:
  - o_x_enable = 0; timeout counter increments each cycle.
  - On i_x_done = 1: capture i_new_addr into o_rd_addr and compute o_rd_blank, go to PRESENT.
  - If the counter reaches C_DONE_TIMEOUT with no done: set o_err, o_rd_addr = 0, o_rd_blank = 1, go to PRESENT.
  - A done arriving on the same cycle the counter reaches C_DONE_TIMEOUT counts as done; o_err stays 0.
- Blank rule (width-safe, 32-bit compare, x zero-extended):
  - Left (o_dir == 0): blank if o_x_off > x.
  - Right: blank if x + o_x_off >= C_WIDTH, using 33-bit sum (no wrap).
- PRESENT:
  - o_rd_valid = 1; o_rd_addr and o_rd_blank held stable until accepted.
  - Accept = o_rd_valid & i_rd_ready; on accept go to ADVANCE (o_rd_valid drops next cycle).
- ADVANCE:
  - If x == C_WIDTH-1: x = 0; then if y == C_HEIGHT-1 go to FIN, else y += 1 and go to ISSUE.
  - Otherwise x += 1, go to ISSUE.
- FIN:
  - o_frame_done = 1 for one cycle, o_busy = 0, go to IDLE.
- Counters never exceed C_WIDTH-1 / C_HEIGHT-1.
- i_start during a frame is ignored; the latched offset is stable for the whole frame.
- Throughput, ready held high: 1 pixel per (3 + done latency) cycles.
- i_x_done seen outside WAIT_DONE is ignored.

Test Plan:
- Left shift, C_WIDTH = 8, C_HEIGHT = 2, off = 3, dir = 0, done 2 cycles after enable, ready high:
  - x = 0..2 -> o_rd_blank = 1; x = 3..7 -> blank 0, o_rd_addr = x-3.
  - 16 accepts, then one o_frame_done pulse; o_busy low after.
- Right shift, off = 5, dir = 1, C_WIDTH = 8:
  - x = 0..2 -> addr x+5, blank 0; x = 3..7 -> blank 1.
  - off = 0xFFFFFFFF -> all blank, no wrap.
- Backpressure: i_rd_ready low 4 cycles during PRESENT -> o_rd_valid, o_rd_addr, o_rd_blank stable; counters frozen; advance only after the accepting cycle.
- Timeout: hold i_x_done = 0 -> after 15 WAIT_DONE cycles o_err = 1, blank pixel presented, scan continues; next i_start clears o_err.
- Reset mid-frame: i_rst_n low for 1 cycle at y = 1, x = 4 -> next cycle all outputs 0, IDLE, no o_frame_done.
- i_start pulsed mid-frame with different off -> ignored; o_x_off unchanged until the frame completes.
